sdram_device_responder: RTL and testbench

//  Synthesizable responder for the SDRAM command bus: the device end of the bus our init and access FSMs drive.

---
 rtl/sdram_device_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_sdram_device_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_device_responder.sv
// rtl/sdram_device_responder.sv - SDRAM device-side responder: command decode, init-sequence checker, banked array, CL-timed read bursts
module sdram_device_responder #(
    parameter int PWR_NOPS = 10000,
    parameter int MIN_REFS = 8,
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic        DRAM_CKE,
    input  logic        DRAM_CS_N,
    input  logic        DRAM_RAS_N,
    input  logic        DRAM_CAS_N,
    input  logic        DRAM_WE_N,
    input  logic [1:0]  DRAM_BA,
    input  logic [12:0] DRAM_ADDR,
    input  logic        DRAM_UDQM,
    input  logic        DRAM_LDQM,
    input  logic [15:0] DRAM_DQ,
    output logic [15:0] odq,
    output logic        odq_oe,
    output logic        oinit_done,
    output logic [12:0] omode_reg,
    output logic [7:0]  oref_count,
    output logic        oerr,
    output logic [2:0]  oerr_code
);
    localparam int NOP_W  = $clog2(PWR_NOPS + 2);
    localparam int ADDR_W = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH  = 4 << (ROW_BITS + COL_BITS);
    localparam logic [NOP_W-1:0] NOP_MAX = NOP_W'(PWR_NOPS);
    localparam logic [7:0]       REF_MIN = 8'(MIN_REFS);

    typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF, CMD_MRS, CMD_BAD} cmd_t;
    typedef enum logic [1:0] {S_PWRUP, S_WAIT_REF, S_READY} state_t;

    cmd_t              cmd;
    state_t            state_q, state_d;
    logic [NOP_W-1:0]  nop_cnt;
    logic [3:0]        bank_open;
    logic [ROW_BITS-1:0] open_row [4];
    logic              err_set, nop_inc, nop_clr, ref_inc, mode_load, act_ok, rw_ok, pre_ok;
    logic [2:0]        err_val;
    logic              a10, any_open, ba_open, mode_ok;
    logic [1:0]        cl_eff, bl_log;
    logic [15:0]       mem [DEPTH];

    logic                rd_active;
    logic [1:0]          rd_bank, rd_wait, rd_len;
    logic [ROW_BITS-1:0] rd_row;
    logic [COL_BITS-1:0] rd_col, rd_mask, rd_col_n;
    logic [3:0]          rd_cnt, rd_last;
    logic                rd_start, rd_stop;
    logic [ADDR_W-1:0]   rd_idx, wr_idx;

    always_comb begin
        cmd = CMD_NOP;
        if (!DRAM_CS_N) begin
            case ({DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N})
                3'b111:  cmd = CMD_NOP;
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_MRS;
                default: cmd = CMD_BAD;
            endcase
        end
    end

    assign a10      = DRAM_ADDR[10];
    assign any_open = |bank_open;
    assign ba_open  = bank_open[DRAM_BA];
    assign mode_ok  = !DRAM_ADDR[2] && (DRAM_ADDR[6:4] == 3'd2 || DRAM_ADDR[6:4] == 3'd3);
    // Out-of-range mode fields fall back to BL=1 / CL=2
    assign cl_eff   = (omode_reg[6:4] == 3'd3) ? 2'd3 : 2'd2;
    assign bl_log   = omode_reg[2] ? 2'd0 : omode_reg[1:0];
    assign oinit_done = (state_q == S_READY);

    always_comb begin
        state_d   = state_q;
        err_set   = 1'b0;
        err_val   = 3'd0;
        nop_inc   = 1'b0;
        nop_clr   = 1'b0;
        ref_inc   = 1'b0;
        mode_load = 1'b0;
        act_ok    = 1'b0;
        rw_ok     = 1'b0;
        pre_ok    = 1'b0;
        if (DRAM_CKE) begin
            if (cmd == CMD_BAD) begin
                err_set = 1'b1; err_val = 3'd7;
            end else begin
                case (state_q)
                    S_PWRUP: begin
                        if (cmd == CMD_NOP) nop_inc = 1'b1;
                        else begin
                            nop_clr = 1'b1;
                            if (nop_cnt < NOP_MAX) begin err_set = 1'b1; err_val = 3'd1; end
                            else if (cmd == CMD_PRE && a10) state_d = S_WAIT_REF;
                            else if (cmd == CMD_PRE) begin err_set = 1'b1; err_val = 3'd5; end
                            else begin err_set = 1'b1; err_val = 3'd2; end
                        end
                    end
                    S_WAIT_REF: begin
                        case (cmd)
                            CMD_REF: ref_inc = 1'b1;
                            CMD_MRS: begin
                                if (oref_count >= REF_MIN) begin
                                    state_d = S_READY; mode_load = 1'b1;
                                    if (!mode_ok) begin err_set = 1'b1; err_val = 3'd3; end
                                end else begin
                                    err_set = 1'b1; err_val = 3'd3;
                                end
                            end
                            CMD_ACT, CMD_READ, CMD_WRITE: begin err_set = 1'b1; err_val = 3'd4; end
                            default: ;
                        endcase
                    end
                    default: begin
                        case (cmd)
                            CMD_REF: begin
                                ref_inc = 1'b1;
                                if (any_open) begin err_set = 1'b1; err_val = 3'd6; end
                            end
                            CMD_MRS: begin
                                if (any_open) begin err_set = 1'b1; err_val = 3'd6; end
                                else begin
                                    mode_load = 1'b1;
                                    if (!mode_ok) begin err_set = 1'b1; err_val = 3'd3; end
                                end
                            end
                            CMD_ACT: begin
                                if (ba_open) begin err_set = 1'b1; err_val = 3'd6; end
                                else act_ok = 1'b1;
                            end
                            CMD_READ, CMD_WRITE: begin
                                if (!ba_open) begin err_set = 1'b1; err_val = 3'd6; end
                                else rw_ok = 1'b1;
                            end
                            CMD_PRE: pre_ok = 1'b1;
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q    <= S_PWRUP;
            nop_cnt    <= '0;
            oref_count <= '0;
            omode_reg  <= '0;
            oerr       <= 1'b0;
            oerr_code  <= 3'd0;
            bank_open  <= '0;
            for (int i = 0; i < 4; i++) open_row[i] <= '0;
        end else begin
            state_q <= state_d;
            if (nop_clr) nop_cnt <= '0;
            else if (nop_inc && nop_cnt != NOP_MAX) nop_cnt <= nop_cnt + NOP_W'(1);
            if (ref_inc && oref_count != 8'hFF) oref_count <= oref_count + 8'd1;
            if (mode_load) omode_reg <= DRAM_ADDR;
            if (err_set && !oerr) begin
                oerr      <= 1'b1;
                oerr_code <= err_val;
            end
            if (act_ok) begin
                bank_open[DRAM_BA] <= 1'b1;
                open_row[DRAM_BA]  <= DRAM_ADDR[ROW_BITS-1:0];
            end
            if (pre_ok) begin
                if (a10) bank_open <= '0;
                else     bank_open[DRAM_BA] <= 1'b0;
            end
        end
    end

    assign wr_idx = {DRAM_BA, open_row[DRAM_BA], DRAM_ADDR[COL_BITS-1:0]};

    always_ff @(posedge iclk) begin
        if (rw_ok && cmd == CMD_WRITE) begin
            if (!DRAM_LDQM) mem[wr_idx][7:0]  <= DRAM_DQ[7:0];
            if (!DRAM_UDQM) mem[wr_idx][15:8] <= DRAM_DQ[15:8];
        end
    end

    // Burst address wraps inside the BL-aligned column block
    assign rd_last  = (4'd1 << rd_len) - 4'd1;
    assign rd_mask  = COL_BITS'(rd_last);
    assign rd_col_n = (rd_col & ~rd_mask) | ((rd_col + COL_BITS'(rd_cnt)) & rd_mask);
    assign rd_idx   = {rd_bank, rd_row, rd_col_n};
    assign rd_start = rw_ok && cmd == CMD_READ;
    assign rd_stop  = (pre_ok && (a10 || DRAM_BA == rd_bank)) ||
                      (rw_ok && cmd == CMD_WRITE && DRAM_BA == rd_bank);

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            rd_active <= 1'b0;
            rd_bank   <= '0;
            rd_row    <= '0;
            rd_col    <= '0;
            rd_cnt    <= '0;
            rd_wait   <= '0;
            rd_len    <= '0;
            odq       <= '0;
            odq_oe    <= 1'b0;
        end else begin
            odq    <= '0;
            odq_oe <= 1'b0;
            if (rd_start) begin
                rd_active <= 1'b1;
                rd_bank   <= DRAM_BA;
                rd_row    <= open_row[DRAM_BA];
                rd_col    <= DRAM_ADDR[COL_BITS-1:0];
                rd_cnt    <= '0;
                rd_wait   <= cl_eff - 2'd1;
                rd_len    <= bl_log;
            end else if (rd_active && rd_stop) begin
                rd_active <= 1'b0;
            end else if (rd_active) begin
                if (rd_wait != 2'd0) rd_wait <= rd_wait - 2'd1;
                else begin
                    odq    <= mem[rd_idx];
                    odq_oe <= 1'b1;
                    rd_cnt <= rd_cnt + 4'd1;
                    if (rd_cnt == rd_last) rd_active <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_device_responder.sv
// tb/tb_sdram_device_responder.sv - randomized self-checking bench for sdram_device_responder
module tb_sdram_device_responder;
    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100,
                           C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;

    logic clk = 1'b0, rst = 1'b1, cke = 1'b1;
    logic cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0] ba = '0;
    logic [12:0] addr = '0;
    logic udqm = 1'b0, ldqm = 1'b0;
    logic [15:0] dq = '0;
    logic [15:0] odq;
    logic odq_oe, oinit_done, oerr;
    logic [12:0] omode_reg;
    logic [7:0] oref_count;
    logic [2:0] oerr_code;

    sdram_device_responder dut (
        .iclk(clk), .ireset(rst), .DRAM_CKE(cke), .DRAM_CS_N(cs_n), .DRAM_RAS_N(ras_n),
        .DRAM_CAS_N(cas_n), .DRAM_WE_N(we_n), .DRAM_BA(ba), .DRAM_ADDR(addr),
        .DRAM_UDQM(udqm), .DRAM_LDQM(ldqm), .DRAM_DQ(dq), .odq(odq), .odq_oe(odq_oe),
        .oinit_done(oinit_done), .omode_reg(omode_reg), .oref_count(oref_count),
        .oerr(oerr), .oerr_code(oerr_code)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    bit exp_oe [int];
    logic [15:0] exp_dq [int];
    logic [15:0] m_mem [4][16][16];
    bit m_open [4];
    int m_row [4];
    int m_bl = 1, m_cl = 2, burst_bank = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check("oe", odq_oe, exp_oe.exists(cyc) ? 1 : 0);
        if (exp_oe.exists(cyc)) check("dq", odq, exp_dq[cyc]);
    endtask

    task automatic clear_from(input int t);
        for (int k = t; k < t + 16; k++) begin
            exp_oe.delete(k);
            exp_dq.delete(k);
        end
    endtask

    task automatic model_reset();
        exp_oe.delete();
        exp_dq.delete();
        for (int i = 0; i < 4; i++) m_open[i] = 0;
        m_bl = 1; m_cl = 2; burst_bank = -1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [15:0] d, input logic [1:0] dqm);
        int t, col, base, cn;
        t = cyc + 1;
        col = int'(a[3:0]);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = b; addr = a; dq = d; {udqm, ldqm} = dqm;
        case (c)
            C_ACT: if (!m_open[b]) begin m_open[b] = 1; m_row[b] = int'(a[3:0]); end
            C_WR: if (m_open[b]) begin
                if (!dqm[0]) m_mem[b][m_row[b]][col][7:0]  = d[7:0];
                if (!dqm[1]) m_mem[b][m_row[b]][col][15:8] = d[15:8];
                if (int'(b) == burst_bank) clear_from(t);
            end
            C_PRE: begin
                if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
                else m_open[b] = 0;
                if (a[10] || int'(b) == burst_bank) clear_from(t);
            end
            C_RD: if (m_open[b]) begin
                clear_from(t);
                burst_bank = int'(b);
                base = col - (col % m_bl);
                for (int n = 0; n < m_bl; n++) begin
                    cn = base + (col + n) % m_bl;
                    exp_oe[t + m_cl + n] = 1;
                    exp_dq[t + m_cl + n] = m_mem[b][m_row[b]][cn];
                end
            end
            C_MRS: begin
                m_bl = a[2] ? 1 : (1 << a[1:0]);
                m_cl = (a[6:4] == 3'd3) ? 3 : 2;
            end
            default: ;
        endcase
        tick();
    endtask

    task automatic nop(input int n);
        repeat (n) issue(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_init(input int nops, input int refs, input logic [12:0] mode);
        nop(nops);
        issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        repeat (refs) begin
            issue(C_REF, 2'd0, 13'd0, 16'd0, 2'b00);
            nop(1);
        end
        issue(C_MRS, 2'd0, mode, 16'd0, 2'b00);
    endtask

    initial begin
        int t4_seq [8];
        int r;
        logic [1:0] b;
        logic [12:0] a;
        t4_seq = '{6, 7, 0, 1, 2, 3, 4, 5};

        do_reset();
        check("rst_dq", odq, 0);
        check("rst_oe", odq_oe, 0);
        check("rst_init", oinit_done, 0);
        check("rst_mode", omode_reg, 0);
        check("rst_refs", oref_count, 0);
        check("rst_err", oerr, 0);
        check("rst_code", oerr_code, 0);

        nop(50);
        issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        check("early_pall_err", oerr, 1);
        check("early_pall_code", oerr_code, 1);

        do_reset();
        do_init(10000, 3, 13'h023);
        check("few_refs_code", oerr_code, 3);
        check("few_refs_refs", oref_count, 3);
        check("few_refs_init", oinit_done, 0);

        do_reset();
        do_init(10000, 8, 13'h023);
        check("init_done", oinit_done, 1);
        check("init_mode", omode_reg, 13'h023);
        check("init_err", oerr, 0);
        check("init_refs", oref_count, 8);

        for (int bk = 0; bk < 4; bk++)
            for (int rw = 0; rw < 16; rw++) begin
                issue(C_ACT, 2'(bk), 13'(rw), 16'd0, 2'b00);
                for (int c = 0; c < 16; c++)
                    issue(C_WR, 2'(bk), 13'(c), 16'($urandom), 2'b00);
                issue(C_PRE, 2'(bk), 13'd0, 16'd0, 2'b00);
            end

        issue(C_ACT, 2'd1, 13'd2, 16'd0, 2'b00);
        issue(C_WR, 2'd1, 13'd5, 16'h1234, 2'b00);
        issue(C_WR, 2'd1, 13'd5, 16'hA55A, 2'b10);
        issue(C_RD, 2'd1, 13'd5, 16'd0, 2'b00);
        nop(1);
        check("t3_oe_early", odq_oe, 0);
        nop(1);
        check("t3_oe", odq_oe, 1);
        check("t3_dq", odq, 16'h125A);
        nop(8);

        for (int c = 0; c < 8; c++) issue(C_WR, 2'd1, 13'(c), 16'(c), 2'b00);
        issue(C_RD, 2'd1, 13'd6, 16'd0, 2'b00);
        for (int k = 1; k <= 10; k++) begin
            nop(1);
            if (k >= 2 && k <= 9) begin
                check("t4_oe", odq_oe, 1);
                check("t4_dq", odq, 16'(t4_seq[k-2]));
            end else begin
                check("t4_oe_off", odq_oe, 0);
            end
        end

        for (int s = 0; s < 2000; s++) begin
            r = $urandom_range(0, 99);
            b = 2'($urandom_range(0, 3));
            if (r < 30) nop(1);
            else if (r < 45) begin
                if (m_open[b]) issue(C_PRE, b, 13'd0, 16'd0, 2'b00);
                else issue(C_ACT, b, 13'($urandom_range(0, 15)), 16'd0, 2'b00);
            end else if (r < 85) begin
                if (!m_open[b]) issue(C_ACT, b, 13'($urandom_range(0, 15)), 16'd0, 2'b00);
                if (r < 65) issue(C_WR, b, 13'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
                else issue(C_RD, b, 13'($urandom_range(0, 15)), 16'd0, 2'($urandom_range(0, 3)));
            end else if (r < 95) begin
                issue(C_PRE, b, 13'($urandom_range(0, 1)) << 10, 16'd0, 2'b00);
            end else begin
                issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
                a = 13'($urandom_range(0, 3)) | (13'($urandom_range(2, 3)) << 4);
                issue(C_MRS, 2'd0, a, 16'd0, 2'b00);
                check("rand_mode", omode_reg, a);
            end
        end
        nop(12);
        check("rand_err", oerr, 0);

        issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        issue(C_RD, 2'd0, 13'd0, 16'd0, 2'b00);
        check("idle_rd_err", oerr, 1);
        check("idle_rd_code", oerr_code, 6);
        for (int k = 0; k < 4; k++) begin
            nop(1);
            check("idle_rd_oe", odq_oe, 0);
        end
        issue(C_ACT, 2'd0, 13'd1, 16'd0, 2'b00);
        issue(C_REF, 2'd0, 13'd0, 16'd0, 2'b00);
        check("ref_open_code", oerr_code, 6);

        issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        issue(C_MRS, 2'd0, 13'h033, 16'd0, 2'b00);
        issue(C_ACT, 2'd2, 13'd3, 16'd0, 2'b00);
        issue(C_RD, 2'd2, 13'd0, 16'd0, 2'b00);
        nop(5);
        check("t6_mid_oe", odq_oe, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_oe", odq_oe, 0);
        check("t6_async_dq", odq, 0);
        model_reset();
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        tick();
        tick();
        rst = 1'b0;
        check("t6_init", oinit_done, 0);
        check("t6_mode", omode_reg, 0);
        check("t6_err", oerr, 0);
        issue(C_ACT, 2'd0, 13'd0, 16'd0, 2'b00);
        check("t6_pwrup_code", oerr_code, 1);
        nop(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
